tests: RTL and testbench

- Registered thermometer-code accumulator-adder.
- Decodes a left-filled thermometer code `d` into a count (0..4) and adds it to a 2-bit base `b`.
- Presents the modulo-4 sum `y` one clock later, plus a carry-out and a code-error flag.
- Used as a small arithmetic front end wherever a thermometer-coded level must offset a binary value.

---
 rtl/tests_pkg.sv | 19 +
 rtl/thermo_decoder.sv | 23 ++
 rtl/tests.sv | 62 ++++++
 tb/tb_tests.sv | 110 +++++++++++
 4 files changed

// File: rtl/tests_pkg.sv
// Shared sizing and helpers for the thermometer-code adder.
// Defaults: 4 thermometer levels, 2-bit base and sum.
package tests_pkg;

  localparam int DW = 4;
  localparam int BW = 2;
  localparam int CW = $clog2(DW + 1);

  // Legal iff no 0 sits above a 1 (ones packed against the MSB).
  function automatic logic is_thermo(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DW - 1; i++) begin
      if (!d[i+1] && d[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/thermo_decoder.sv
// Combinational thermometer decoder: popcount plus legality.
// Count is a plain popcount, so illegal codes still decode.
module thermo_decoder #(
  parameter int DW = 4,
  parameter int CW = $clog2(DW + 1)
) (
  input  logic [DW-1:0] d,
  output logic [CW-1:0] count,
  output logic          legal
);

  always_comb begin
    count = '0;
    legal = 1'b1;
    for (int i = 0; i < DW; i++) begin
      count = count + CW'(d[i]);
    end
    for (int i = 0; i < DW - 1; i++) begin
      if (!d[i+1] && d[i]) legal = 1'b0;
    end
  end

endmodule

// File: rtl/tests.sv
// Registered thermometer accumulator-adder: y = (b + count(d)) mod 2**BW.
// All outputs come straight from flops; one result per clock.
module tests
  import tests_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int BW_P = BW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW_P-1:0] d,
  input  logic [BW_P-1:0] b,
  output logic [BW_P-1:0] y,
  output logic            co,
  output logic            code_err
);

  localparam int CW_P = $clog2(DW_P + 1);
  // Sum must hold both operands at full width plus one carry bit.
  localparam int SW = ((BW_P > CW_P) ? BW_P : CW_P) + 1;

  logic [CW_P-1:0] count;
  logic            legal;
  logic [SW-1:0]   sum;

  logic [BW_P-1:0] y_d, y_q;
  logic            co_d, co_q;
  logic            err_d, err_q;

  thermo_decoder #(
    .DW (DW_P),
    .CW (CW_P)
  ) u_dec (
    .d     (d),
    .count (count),
    .legal (legal)
  );

  always_comb begin
    sum   = SW'(b) + SW'(count);
    y_d   = sum[BW_P-1:0];
    co_d  = |sum[SW-1:BW_P];
    err_d = ~legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q   <= '0;
      co_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      co_q  <= co_d;
      err_q <= err_d;
    end
  end

  assign y        = y_q;
  assign co       = co_q;
  assign code_err = err_q;

endmodule

// File: tb/tb_tests.sv
// Bench for tests: directed plan items plus random back-to-back traffic
// against an arithmetic reference model.
module tb_tests;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d;
  logic [1:0] b;
  logic [1:0] y;
  logic       co;
  logic       code_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tests dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .b        (b),
    .y        (y),
    .co       (co),
    .code_err (code_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_count(input int v);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic int ref_legal(input int v);
    return (v == 0 || v == 8 || v == 12 || v == 14 || v == 15) ? 1 : 0;
  endfunction

  // Drive one sample, clock it in, and compare just after the edge.
  task automatic step(input string tag, input logic r,
                      input int dv, input int bv);
    int s;
    @(negedge clk);
    reset = r;
    d     = 4'(dv);
    b     = 2'(bv);
    @(posedge clk);
    #1;
    s = bv + ref_count(dv);
    if (r) begin
      check({tag, ".y"}, int'(y), 0);
      check({tag, ".co"}, int'(co), 0);
      check({tag, ".err"}, int'(code_err), 0);
    end else begin
      check({tag, ".y"}, int'(y), s % 4);
      check({tag, ".co"}, int'(co), (s >= 4) ? 1 : 0);
      check({tag, ".err"}, int'(code_err), 1 - ref_legal(dv));
    end
  endtask

  int legal_codes [4] = '{8, 12, 14, 15};

  initial begin
    reset = 1'b1;
    d     = 4'hF;
    b     = 2'd3;

    step("rst0", 1'b1, 15, 3);
    step("rst1", 1'b1, 15, 3);
    step("first", 1'b0, 8, 0);

    for (int bi = 0; bi < 4; bi++) begin
      for (int k = 0; k < 4; k++) begin
        step($sformatf("sweep_b%0d_k%0d", bi, k + 1), 1'b0,
             legal_codes[k], bi);
      end
    end

    step("zero", 1'b0, 0, 2);
    step("ill0100", 1'b0, 4, 1);
    step("ill1010", 1'b0, 10, 3);
    step("ill0001", 1'b0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("b2b%0d", i), 1'b0,
           legal_codes[i % 4], (i * 3) % 4);
    end

    step("pre_mrst", 1'b0, 14, 3);
    step("mrst", 1'b1, 15, 3);
    step("post_mrst", 1'b0, 12, 1);

    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
